// File: rtl/led_hex_pkg.sv
// Shared types, anode/segment constants and decode helpers for the 7-segment bus capture.
package led_hex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_ACCEPT = 2'd2,
        ST_HELD   = 2'd3
    } state_t;

    localparam logic [3:0] AN_D0    = 4'b1110;
    localparam logic [3:0] AN_D1    = 4'b1101;
    localparam logic [3:0] AN_D2    = 4'b1011;
    localparam logic [3:0] AN_D3    = 4'b0111;
    localparam logic [3:0] AN_BLANK = 4'b1111;

    // Active-low cathode patterns (g..a), entry n displays hex digit n
    localparam logic [15:0][6:0] SEG_TAB = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    // Returns {ok, nibble}; ok = 0 for patterns outside the table
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++)
            if (SEG_TAB[i] == seg) r = {1'b1, 4'(i)};
        return r;
    endfunction

    function automatic logic an_valid(input logic [3:0] an);
        return (an == AN_D0) || (an == AN_D1) || (an == AN_D2) || (an == AN_D3);
    endfunction

    function automatic logic [1:0] an_index(input logic [3:0] an);
        logic [1:0] k;
        case (an)
            AN_D1:   k = 2'd1;
            AN_D2:   k = 2'd2;
            AN_D3:   k = 2'd3;
            default: k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/led_hex_sync.sv
// Two-flop synchronizer; resets to all-ones so the bus reads as blank.
module led_hex_sync #(
    parameter int W = 12
) (
    input  logic         sclk,
    input  logic         reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_ff1;
    logic [W-1:0] r_ff2;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_ff1 <= '1;
            r_ff2 <= '1;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;
endmodule

// File: rtl/led_hex_capture.sv
// Captures a multiplexed 4-digit 7-segment bus back into a 16-bit number.
// Optional macro LED_HEX_CAPTURE_DP_EN: also capture decimal points into dp.
module led_hex_capture
    import led_hex_pkg::*;
#(
    parameter int SETTLE  = 2,
    parameter int TIMEOUT = 65535
) (
    input  logic        sclk,
    input  logic        reset,
    input  logic [7:0]  led_c,
    input  logic [3:0]  led_a,
    output logic [15:0] number,
    output logic        valid,
    output logic        seg_err,
    output logic [3:0]  dp
);
`ifdef LED_HEX_CAPTURE_DP_EN
    localparam logic [11:0] CMP_MASK = 12'hFFF;
`else
    localparam logic [11:0] CMP_MASK = 12'hF7F;
`endif
    localparam logic [7:0] SET_N = 8'(SETTLE);
    localparam state_t     FIRST = (SETTLE == 1) ? ST_ACCEPT : ST_SETTLE;

    logic [11:0]     w_s;
    logic            w_same, w_dig, w_acc, w_done, w_tmo;
    logic [1:0]      w_k, w_slot;
    logic [4:0]      w_dec;
    logic [3:0]      w_seen_nx;
    logic            w_err_nx;

    state_t          r_state;
    logic [7:0]      r_cnt;
    logic [11:0]     r_snap;
    logic [3:0]      r_seen;
    logic            r_err;
    logic [15:0]     r_tmo;
    logic [3:0][3:0] r_shadow;

    led_hex_sync #(.W(12)) u_sync (
        .sclk  (sclk),
        .reset (reset),
        .i_d   ({led_a, led_c}),
        .o_q   (w_s)
    );

    assign w_same = ((w_s ^ r_snap) & CMP_MASK) == 12'h000;
    assign w_dig  = an_valid(w_s[11:8]);
    assign w_k    = an_index(r_snap[11:8]);
    assign w_slot = 2'd3 - w_k;
    // Decode the settled snapshot, not the live sample, so a change in the ACCEPT cycle cannot leak in
    assign w_dec  = seg_decode(r_snap[6:0]);
    assign w_acc  = (r_state == ST_ACCEPT);
    assign w_done = (r_seen == 4'hF);
    assign w_tmo  = (r_seen != 4'h0) && ((17'(r_tmo) + 17'd1) == 17'(TIMEOUT));

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 8'd0;
            r_snap  <= '1;
        end else begin
            case (r_state)
                ST_IDLE: if (w_dig) begin
                    r_snap  <= w_s;
                    r_cnt   <= 8'd1;
                    r_state <= FIRST;
                end
                ST_SETTLE: if (w_same) begin
                    r_cnt <= r_cnt + 8'd1;
                    if (r_cnt + 8'd1 == SET_N) r_state <= ST_ACCEPT;
                end else begin
                    r_snap  <= w_s;
                    r_cnt   <= w_dig ? 8'd1 : 8'd0;
                    r_state <= w_dig ? FIRST : ST_IDLE;
                end
                ST_ACCEPT: r_state <= ST_HELD;
                default: if (!w_same) begin
                    r_snap  <= w_s;
                    r_cnt   <= w_dig ? 8'd1 : 8'd0;
                    r_state <= w_dig ? FIRST : ST_IDLE;
                end
            endcase
        end
    end

    // A digit accepted in the completion/timeout cycle starts the next frame
    always_comb begin
        w_seen_nx = (w_done || w_tmo) ? 4'h0 : r_seen;
        w_err_nx  = (w_done || w_tmo) ? 1'b0 : r_err;
        if (w_acc) begin
            w_seen_nx[w_k] = 1'b1;
            if (!w_dec[4]) w_err_nx = 1'b1;
        end
    end

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_seen   <= 4'h0;
            r_err    <= 1'b0;
            r_tmo    <= 16'd0;
            r_shadow <= '0;
            number   <= 16'h0000;
            valid    <= 1'b0;
            seg_err  <= 1'b0;
        end else begin
            r_seen <= w_seen_nx;
            r_err  <= w_err_nx;
            valid  <= w_done;
            if (w_acc || w_done || w_tmo || r_seen == 4'h0) r_tmo <= 16'd0;
            else                                            r_tmo <= r_tmo + 16'd1;
            if (w_acc) r_shadow[w_slot] <= w_dec[4] ? w_dec[3:0] : 4'h0;
            if (w_done) begin
                number  <= r_shadow;
                seg_err <= r_err;
            end
        end
    end

`ifdef LED_HEX_CAPTURE_DP_EN
    logic [3:0] r_shadow_dp;
    logic [3:0] r_dp;

    always_ff @(posedge sclk or posedge reset) begin
        if (reset) begin
            r_shadow_dp <= 4'h0;
            r_dp        <= 4'h0;
        end else begin
            if (w_acc)  r_shadow_dp[w_k] <= ~r_snap[7];
            if (w_done) r_dp <= r_shadow_dp;
        end
    end

    assign dp = r_dp;
`else
    assign dp = 4'h0;
`endif

endmodule
